// File: rtl/rbs_pipe.sv
// Pipelined ripple-borrow subtractor: diff = a - b - bin, resolved CHUNK bits per stage.
// Valid/ready on both sides; the whole pipe advances or holds as one.
module rbs_pipe #(
  parameter int N     = 8,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_in,
  output logic         ready_in,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         valid_out,
  input  logic         ready_out,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int STAGES = N / CHUNK;
  localparam int PIPE   = (STAGES > 1) ? STAGES - 1 : 1;

  logic              adv;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] br_q, br_d;
  logic [N-1:0]      diff_q [STAGES];
  logic [N-1:0]      diff_d [STAGES];
  // Operands are only needed up to the stage before the last one.
  logic [N-1:0]      a_q [PIPE];
  logic [N-1:0]      a_d [PIPE];
  logic [N-1:0]      b_q [PIPE];
  logic [N-1:0]      b_d [PIPE];
  logic              ovf_q, ovf_d;

  logic [N-1:0]      src_a    [STAGES];
  logic [N-1:0]      src_b    [STAGES];
  logic [N-1:0]      src_diff [STAGES];
  logic [STAGES-1:0] src_br;
  logic [STAGES-1:0] src_vld;
  logic [CHUNK:0]    chunk_res;

  function automatic logic [CHUNK:0] sub_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             bi);
    logic             br;
    logic [CHUNK-1:0] d;
    br = bi;
    d  = '0;
    for (int j = 0; j < CHUNK; j++) begin
      d[j] = x[j] ^ y[j] ^ br;
      br   = (~x[j] & y[j]) | (~(x[j] ^ y[j]) & br);
    end
    return {br, d};
  endfunction

  assign adv       = ~vld_q[STAGES-1] | ready_out;
  assign ready_in  = adv;
  assign valid_out = vld_q[STAGES-1];
  assign diff      = diff_q[STAGES-1];
  assign bout      = br_q[STAGES-1];
  assign ovf       = ovf_q;

  // Stage k sees the primary inputs (k = 0) or the registers of stage k-1.
  always_comb begin
    src_a[0]    = a;
    src_b[0]    = b;
    src_diff[0] = '0;
    src_br[0]   = bin;
    src_vld[0]  = valid_in;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k]    = a_q[k-1];
      src_b[k]    = b_q[k-1];
      src_diff[k] = diff_q[k-1];
      src_br[k]   = br_q[k-1];
      src_vld[k]  = vld_q[k-1];
    end
  end

  always_comb begin
    vld_d     = vld_q;
    br_d      = br_q;
    ovf_d     = ovf_q;
    diff_d    = diff_q;
    a_d       = a_q;
    b_d       = b_q;
    chunk_res = '0;
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        chunk_res = sub_chunk(src_a[k][k*CHUNK +: CHUNK],
                              src_b[k][k*CHUNK +: CHUNK], src_br[k]);
        diff_d[k] = src_diff[k];
        diff_d[k][k*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        br_d[k]   = chunk_res[CHUNK];
        vld_d[k]  = src_vld[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_d[k] = src_a[k];
        b_d[k] = src_b[k];
      end
      ovf_d = (src_a[STAGES-1][N-1] ^ src_b[STAGES-1][N-1]) &
              (diff_d[STAGES-1][N-1] ^ src_a[STAGES-1][N-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      br_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) diff_q[k] <= '0;
      for (int k = 0; k < PIPE; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      br_q   <= br_d;
      ovf_q  <= ovf_d;
      diff_q <= diff_d;
      a_q    <= a_d;
      b_q    <= b_d;
    end
  end

endmodule

// File: tb/tb_rbs_pipe.sv
// Self-checking bench for rbs_pipe (N=8, CHUNK=4): directed cases, back-to-back,
// backpressure, mid-flight reset and random traffic against an arithmetic model.
module tb_rbs_pipe;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_in;
  logic         ready_in;
  logic [N-1:0] a, b;
  logic         bin;
  logic         valid_out;
  logic         ready_out;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  int total = 0;
  int bad   = 0;
  int handoffs = 0;

  logic [N+1:0] exp_q [$];
  logic         stall_prev = 1'b0;
  logic [N+1:0] held;

  rbs_pipe #(.N(N), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
    .a(a), .b(b), .bin(bin), .valid_out(valid_out), .ready_out(ready_out),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {diff, bout, ovf} from plain unsigned arithmetic and the sign rule.
  function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic bi);
    logic [N:0] full;
    logic       o;
    full = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bi};
    o    = (x[N-1] ^ y[N-1]) & (full[N-1] ^ x[N-1]);
    return {full[N-1:0], full[N], o};
  endfunction

  // Scoreboard: inputs are stable at negedge, so this sees exactly what the next edge does.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      chk("ready_in_rule", 32'(ready_in), 32'(!valid_out || ready_out));
      if (stall_prev) chk("hold_stable", 32'({diff, bout, ovf}), 32'(held));
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
        else chk("result", 32'({diff, bout, ovf}), 32'(exp_q.pop_front()));
        handoffs++;
      end
      if (valid_in && ready_in) exp_q.push_back(model(a, b, bin));
      stall_prev = valid_out && !ready_out;
      held       = {diff, bout, ovf};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    valid_in = 1'b0;
    ready_out = 1'b1;
    while ((exp_q.size() != 0 || valid_out) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_one(input logic [7:0] x, input logic [7:0] y, input logic bi,
                         input logic [7:0] ed, input logic eb, input logic eo, input string tag);
    a = x; b = y; bin = bi; valid_in = 1'b1; ready_out = 1'b1;
    tick();
    valid_in = 1'b0;
    chk({tag, "_early"}, 32'(valid_out), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(valid_out), 32'd1);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_bout"}, 32'(bout), 32'(eb));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    drain();
  endtask

  initial begin
    int cnt;
    int h0;
    logic [N+1:0] first;
    rst_n = 1'b0; valid_in = 1'b0; ready_out = 1'b1; a = '0; b = '0; bin = 1'b0;
    repeat (3) tick();
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_outputs", 32'({diff, bout, ovf}), 32'd0);
    chk("rst_ready_in", 32'(ready_in), 32'd1);
    rst_n = 1'b1;
    tick();

    run_one(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, "basic");
    run_one(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "wrap");
    run_one(8'h10, 8'h00, 1'b1, 8'h0F, 1'b0, 1'b0, "chunk_borrow");
    run_one(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "ovf_neg");
    run_one(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "ovf_pos");
    run_one(8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, "equal");
    run_one(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, "full_wrap");

    // Back-to-back throughput
    cnt = 0;
    h0 = handoffs;
    ready_out = 1'b1;
    for (int i = 0; i < 18; i++) begin
      valid_in = (i < 16);
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      tick();
      if (valid_out) cnt++;
    end
    chk("b2b_valid_cycles", 32'(cnt), 32'd16);
    drain();
    chk("b2b_handoffs", 32'(handoffs - h0), 32'd16);

    // Backpressure: two ops fill the pipe, third waits on ready_in
    h0 = handoffs;
    ready_out = 1'b0;
    valid_in = 1'b1;
    a = 8'h91; b = 8'h22; bin = 1'b0;
    tick();
    a = 8'h05; b = 8'h06; bin = 1'b1;
    tick();
    a = 8'hC3; b = 8'h3C; bin = 1'b0;
    first = model(8'h91, 8'h22, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready_in", 32'(ready_in), 32'd0);
      chk("bp_valid_out", 32'(valid_out), 32'd1);
      chk("bp_held_data", 32'({diff, bout, ovf}), 32'(first));
      tick();
    end
    ready_out = 1'b1;
    tick();
    valid_in = 1'b0;
    drain();
    chk("bp_handoffs", 32'(handoffs - h0), 32'd3);

    // Reset with two operations in flight
    h0 = handoffs;
    ready_out = 1'b0;
    valid_in = 1'b1;
    a = 8'h44; b = 8'h11; bin = 1'b0;
    tick();
    a = 8'h99; b = 8'h98; bin = 1'b1;
    tick();
    valid_in = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_valid_out", 32'(valid_out), 32'd0);
    chk("mrst_outputs", 32'({diff, bout, ovf}), 32'd0);
    chk("mrst_ready_in", 32'(ready_in), 32'd1);
    ready_out = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid_out) cnt++;
    end
    chk("mrst_no_emit", 32'(cnt), 32'd0);
    chk("mrst_handoffs", 32'(handoffs - h0), 32'd0);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      valid_in  = ($urandom_range(0, 3) != 0);
      ready_out = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: a = 8'h00;
        1: a = 8'hFF;
        2: a = 8'h80;
        default: a = 8'($urandom);
      endcase
      b   = ($urandom_range(0, 4) == 0) ? a : 8'($urandom);
      bin = 1'($urandom);
      tick();
    end
    drain();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rbs_pipe.md
Name: rbs_pipe

Overview:
- Pipelined N-bit ripple-borrow subtractor: computes diff = a - b - bin.
- Complements the combinational ripple-carry adder in the arithmetic library.
- Borrow chain is broken into CHUNK-bit segments, one pipeline register per segment, so wide subtractors close timing.
- Valid/ready on both sides; sits between operand-producing logic and a result consumer that may stall.

Parameters:
- N, 8, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; STAGES = N/CHUNK (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- valid_in  input  1  operand set present
- ready_in  output  1  block can accept operands this cycle
- a  input  N  minuend, unsigned or two's-complement
- b  input  N  subtrahend
- bin  input  1  borrow in
- valid_out  output  1  result present
- ready_out  input  1  consumer accepts result this cycle
- diff  output  N  a - b - bin, modulo 2^N
- bout  output  1  borrow out; 1 when unsigned a < b + bin
- ovf  output  1  signed overflow; 1 when sign(a) != sign(b) and sign(diff) != sign(a)

Behaviour:
- Reset: rst_n sampled low at a clk edge clears every stage valid bit, valid_out, diff, bout and ovf to 0. Data registers other than the outputs may also be cleared.
- Reset mid-operation: all in-flight operations are discarded; none ever appear at the output.
- ready_in is 1 the cycle after reset.
- Advance enable: adv = ~valid_out | ready_out. ready_in = adv, combinational; no combinational path from valid_in to ready_in.
- Accept: an operand set is taken when valid_in & ready_in.
- Pipeline advance: when adv = 1, every stage loads from its predecessor, including bubbles; stage 0 loads valid_in. When adv = 0, all stages hold.
- No bubble collapse is required.
- Stage k (0..STAGES-1) resolves result bits [k*CHUNK +: CHUNK] from:
  - the borrow registered by stage k-1 (stage 0 uses bin);
  - operand bits carried forward through the preceding registers.
- Per bit: d = x ^ y ^ br; br_next = (~x & y) | (~(x ^ y) & br).
- Skew alignment:
  - Result chunks produced early are delayed so all N bits, bout and ovf leave together in the final stage.
  - Unused upper operand bits travel with their stage.
  - Operand bits no longer needed may be dropped.
- Latency: exactly STAGES cycles from the accept edge to valid_out = 1, when no stall occurs.
- Throughput: one operation per cycle while ready_out = 1.
- Output holding: while valid_out & ~ready_out, diff, bout and ovf are stable and no data is lost or reordered.
- Results emerge in acceptance order.
- bout is the borrow out of bit N-1. ovf = (a[N-1] ^ b[N-1]) & (diff[N-1] ^ a[N-1]), using the a and b of the same operation.
- STAGES = 1: a single registered subtractor with the same handshake.
- Simultaneous accept and output handoff in one cycle is legal and must not drop or duplicate any operation.
- Boundaries:
  - a = b, bin = 0 -> diff 0, bout 0.
  - a = 0, b = 2^N-1, bin = 1 -> diff 0, bout 1 (full wrap).
  - borrow ripples through every chunk boundary.

Test Plan:
- N=8, CHUNK=4, ready_out=1: a=0x35, b=0x12, bin=0 -> 2 cycles later diff=0x23, bout=0, ovf=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0. Also a=0x10, b=0x00, bin=1 -> diff=0x0F; verifies the borrow crosses the chunk register.
- a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0. a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1.
- Back-to-back: 16 random operations with valid_in held high and ready_out=1 -> 16 consecutive valid_out cycles. Each result matches a reference model. Throughput is 1/cycle.
- Backpressure:
  - Drive 3 operations, then hold ready_out=0 for 5 cycles -> ready_in=0 while valid_out=1, and outputs stay stable.
  - Release ready_out -> the 3 results appear in order, with none lost or duplicated.
- Reset: assert rst_n=0 for one cycle with 2 operations in flight -> valid_out=0 and diff/bout/ovf=0 next cycle. Neither operation is ever emitted, and ready_in=1 afterward.
